// File: rtl/isolator_spi_pkg.sv
// Shared types for the isolator SPI arbiter: command layout, frame size and FSM states.
package isolator_spi_pkg;

   localparam int SPI_FRAME_BITS = 16;

   typedef struct packed {
      logic       rw;
      logic [6:0] addr;
      logic [7:0] data;
   } spi_cmd_t;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, RESP, GAP} spi_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from last_grant+1.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant_oh,
   output logic [IW-1:0]      grant_idx,
   input  logic               upd,
   input  logic [IW-1:0]      upd_idx
);

   logic [IW-1:0] last_grant;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)    last_grant <= IW'(NUM_REQ - 1);
      else if (upd) last_grant <= upd_idx;
   end

   always_comb begin
      logic          found;
      logic [IW-1:0] idx;
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IW'((int'(last_grant) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            found         = 1'b1;
            grant_oh[idx] = 1'b1;
            grant_idx     = idx;
         end
      end
   end

endmodule

// File: rtl/isolator_spi_arbiter.sv
// Shares one isolator SPI bus between NUM_REQ ready/valid command ports;
// one mode-0 16-bit frame per accepted command, read byte returned per port.
module isolator_spi_arbiter
   import isolator_spi_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int SCLK_DIV   = 4,
   parameter int GAP_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    cmd_valid,
   output logic [NUM_REQ-1:0]    cmd_ready,
   input  logic [16*NUM_REQ-1:0] cmd_data,
   output logic [NUM_REQ-1:0]    resp_valid,
   input  logic [NUM_REQ-1:0]    resp_ready,
   output logic [8*NUM_REQ-1:0]  resp_data,
   output logic                  sclk,
   output logic                  cs_n,
   output logic                  mosi,
   input  logic                  miso
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int HW = $clog2(SCLK_DIV + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [HW-1:0] H_LAST = HW'(SCLK_DIV - 1);
   localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [4:0]    B_LAST = 5'(SPI_FRAME_BITS - 1);

   spi_arb_state_t state, state_nxt;

   logic [NUM_REQ-1:0][15:0] cmd_arr;
   logic [NUM_REQ-1:0][7:0]  resp_q;
   logic [NUM_REQ-1:0]       grant_oh;
   logic [IW-1:0]            grant_idx, gidx;
   logic [NUM_REQ-1:0]       cmd_ready_q;
   logic [HW-1:0]            hcnt;
   logic [GW-1:0]            gcnt;
   logic [4:0]               bcnt;
   logic [15:0]              sr;
   logic [7:0]               rx;
   logic                     rw_q, sclk_q;
   logic                     accept, offer, h_end, g_end, last_fall;
   spi_cmd_t                 cmd_sel;

   assign cmd_arr   = cmd_data;
   assign resp_data = resp_q;
   assign cmd_ready = cmd_ready_q;
   assign cmd_sel   = spi_cmd_t'(cmd_arr[gidx]);
   assign sclk      = sclk_q;
   assign mosi      = cs_n ? 1'b0 : sr[15];

   assign h_end     = (hcnt == H_LAST);
   assign g_end     = (gcnt == G_LAST);
   assign last_fall = h_end && sclk_q && (bcnt == B_LAST);
   assign accept    = (state == IDLE) && |(cmd_ready_q & cmd_valid);
   // ready is registered one cycle ahead so it never follows valid combinationally;
   // offering from the last GAP cycle keeps the accept spacing tight.
   assign offer     = (|cmd_valid) &&
                      (((state == GAP) && g_end) || ((state == IDLE) && !(|cmd_ready_q)));

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
      .clk       (clk),
      .reset     (reset),
      .req       (cmd_valid),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .upd       (accept),
      .upd_idx   (gidx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      cs_n       = 1'b1;
      resp_valid = '0;
      case (state)
         IDLE:  if (accept) state_nxt = SETUP;
         SETUP: begin
            cs_n = 1'b0;
            if (h_end) state_nxt = SHIFT;
         end
         SHIFT: begin
            cs_n = 1'b0;
            if (last_fall) state_nxt = HOLD;
         end
         HOLD: begin
            cs_n = 1'b0;
            if (h_end) state_nxt = rw_q ? RESP : GAP;
         end
         RESP: begin
            resp_valid[gidx] = 1'b1;
            if (resp_ready[gidx]) state_nxt = GAP;
         end
         GAP:     if (g_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_ready_q <= '0;
         gidx        <= '0;
         hcnt        <= '0;
         gcnt        <= '0;
         bcnt        <= '0;
         sr          <= '0;
         rx          <= '0;
         rw_q        <= 1'b0;
         sclk_q      <= 1'b0;
         resp_q      <= '0;
      end else begin
         cmd_ready_q <= offer ? grant_oh : '0;
         if (offer) gidx <= grant_idx;

         if (state_nxt != state)
            hcnt <= '0;
         else if (state == SETUP || state == SHIFT || state == HOLD)
            hcnt <= h_end ? '0 : hcnt + 1'b1;

         if (state != GAP || state_nxt != GAP) gcnt <= '0;
         else                                  gcnt <= gcnt + 1'b1;

         if (state != SHIFT || state_nxt != SHIFT) bcnt <= '0;
         else if (h_end && sclk_q)                 bcnt <= bcnt + 1'b1;

         if (state == SHIFT && h_end) sclk_q <= ~sclk_q;
         else if (state != SHIFT)     sclk_q <= 1'b0;

         if (accept) begin
            sr   <= cmd_sel;
            rw_q <= cmd_sel.rw;
            rx   <= '0;
         end else if (state == SHIFT && h_end) begin
            if (!sclk_q)        rx <= {rx[6:0], miso};
            else if (!last_fall) sr <= {sr[14:0], 1'b0};
         end

         if (state == HOLD && h_end && rw_q) resp_q[gidx] <= rx;
      end
   end

endmodule
